// File: rtl/sram_ctrl_pkg.sv
// Shared sizing and types for the single-port SRAM arbiter and its read-return buffer.
package sram_ctrl_pkg;
  localparam int DATA_W     = 128;
  localparam int ADDR_W     = 11;
  localparam int SRAM_DEPTH = 2048;
  localparam int RDQ_DEPTH  = 2;
  localparam int RDQ_OCC_W  = $clog2(RDQ_DEPTH + 1);

  typedef enum logic {
    GNT_RD = 1'b0,
    GNT_WR = 1'b1
  } gnt_side_e;
endpackage

// File: rtl/rd_fifo_2x128.sv
// Two-entry read-return buffer; the head is always presented on pop_data.
module rd_fifo_2x128
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_W = sram_ctrl_pkg::DATA_W
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 push,
  input  logic [DATA_W-1:0]    push_data,
  input  logic                 pop,
  output logic [DATA_W-1:0]    pop_data,
  output logic                 valid,
  output logic [RDQ_OCC_W-1:0] occ
);

  logic [DATA_W-1:0]    head_reg;
  logic [DATA_W-1:0]    tail_reg;
  logic [RDQ_OCC_W-1:0] occ_reg;
  logic                 pop_eff;
  logic                 push_eff;

  // A pop on an empty buffer is ignored; a push into a full buffer only lands if a pop frees a slot.
  assign pop_eff  = pop && (occ_reg != '0);
  assign push_eff = push && ((occ_reg != RDQ_OCC_W'(RDQ_DEPTH)) || pop_eff);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      head_reg <= '0;
      tail_reg <= '0;
      occ_reg  <= '0;
    end else begin
      unique case ({push_eff, pop_eff})
        2'b10: begin
          if (occ_reg == '0) head_reg <= push_data;
          else               tail_reg <= push_data;
          occ_reg <= occ_reg + RDQ_OCC_W'(1);
        end
        2'b01: begin
          head_reg <= tail_reg;
          occ_reg  <= occ_reg - RDQ_OCC_W'(1);
        end
        2'b11: begin
          if (occ_reg == RDQ_OCC_W'(1)) begin
            head_reg <= push_data;
          end else begin
            head_reg <= tail_reg;
            tail_reg <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign pop_data = head_reg;
  assign valid    = (occ_reg != '0);
  assign occ      = occ_reg;

endmodule

// File: rtl/sram_arb_128b.sv
// Round-robin arbiter sharing one single-port SRAM between a write port and a read port
// with a small return buffer; read data arrives one edge after the read is accepted.
module sram_arb_128b
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_W = sram_ctrl_pkg::DATA_W,
  parameter int ADDR_W = sram_ctrl_pkg::ADDR_W
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_gnt,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              sram_cen,
  output logic              sram_wen,
  output logic [ADDR_W-1:0] sram_a,
  output logic [DATA_W-1:0] sram_d,
  input  logic [DATA_W-1:0] sram_q
);

  logic [RDQ_OCC_W-1:0] occ;
  logic                 pend_reg;
  gnt_side_e            last_reg;
  logic                 pop;
  logic [2:0]           in_flight;
  logic                 rd_elig;
  logic                 rd_cand;

  // Reads in flight after this edge (buffered + on the SRAM bus - leaving) must fit the buffer.
  assign pop       = rd_valid && rd_ready;
  assign in_flight = 3'(occ) + {2'b0, pend_reg} - {2'b0, pop};
  assign rd_elig   = (in_flight < 3'(RDQ_DEPTH));
  assign rd_cand   = rd_req && rd_elig;

  // RST_N gates the grants so the SRAM is idle the moment reset asserts.
  always_comb begin
    wr_gnt = RST_N && wr_req && (!rd_cand || (last_reg == GNT_RD));
    rd_gnt = RST_N && rd_cand && (!wr_req || (last_reg == GNT_WR));
  end

  always_comb begin
    sram_cen = 1'b1;
    sram_wen = 1'b1;
    sram_a   = '0;
    sram_d   = '0;
    if (wr_gnt) begin
      sram_cen = 1'b0;
      sram_wen = 1'b0;
      sram_a   = wr_addr;
      sram_d   = wr_data;
    end else if (rd_gnt) begin
      sram_cen = 1'b0;
      sram_a   = rd_addr;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pend_reg <= 1'b0;
      last_reg <= GNT_RD;
    end else begin
      pend_reg <= rd_gnt;
      if (wr_gnt)      last_reg <= GNT_WR;
      else if (rd_gnt) last_reg <= GNT_RD;
    end
  end

  rd_fifo_2x128 #(
    .DATA_W (DATA_W)
  ) u_rd_fifo (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .push      (pend_reg),
    .push_data (sram_q),
    .pop       (pop),
    .pop_data  (rd_data),
    .valid     (rd_valid),
    .occ       (occ)
  );

endmodule
